// File: rtl/key_matrix_map_if.sv
// key_matrix_map_if: scancode, keymap-load and matrix-scan signals between host/CPU and key_matrix_map
interface key_matrix_map_if #(
  parameter int ROWS = 8,
  parameter int COLS = 5,
  parameter int NAUX = 4
);
  localparam int KW = $clog2(ROWS) + $clog2(COLS);
  logic              strb;
  logic [7:0]        code;
  logic              clear_all;
  logic              map_we;
  logic [8:0]        map_addr;
  logic [2*KW+1:0]   map_data;
  logic [ROWS-1:0]   row;
  logic [COLS-1:0]   col;
  logic [NAUX-1:0]   aux;
  modport master (output strb, code, clear_all, map_we, map_addr, map_data, row, input col, aux);
  modport slave (input strb, code, clear_all, map_we, map_addr, map_data, row, output col, aux);
endinterface

// File: rtl/key_matrix_map.sv
// key_matrix_map: PS/2 set-2 scancode decoder driving a keymapped active-low key matrix and aux lines
module key_matrix_map #(
  parameter int ROWS = 8,
  parameter int COLS = 5,
  parameter int NAUX = 4,
  parameter int TIMEOUT = 65535
) (
  input logic clk,
  input logic rst,
  key_matrix_map_if.slave bus
);
  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam int KW = RW + CW;
  localparam int MW = 2 + 2 * KW;
  localparam int NK = ROWS * COLS;
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, BRK, EXT, EXT_BRK, SKIP} state_t;
  typedef struct packed {
    logic       v;
    logic       brk;
    logic       clr;
    logic [8:0] addr;
  } ev_t;
  state_t st_q, st_d;
  logic [TW-1:0] to_q, to_d;
  logic [2:0] skip_q, skip_d;
  ev_t ev, s1_q, s1_d, s2_q, s2_d;
  logic [MW-1:0] map_mem [512];
  logic [MW-1:0] ent_q;
  logic [1:0] kind;
  logic [KW-1:0] a, b;
  logic [NK-1:0][1:0] ctr_q, ctr_d;
  logic [511:0] down_q, down_d;
  logic [NAUX-1:0] aux_q, aux_d;
  logic apply, clear;
  assign {kind, a, b} = ent_q;
  assign bus.aux = aux_q;
  // Parser: turns prefix bytes into make/break/clear events, with a prefix timeout
  always_comb begin
    st_d = st_q;
    to_d = '0;
    skip_d = skip_q;
    ev = '0;
    ev.addr = {1'b0, bus.code};
    if (bus.strb) begin
      case (st_q)
        IDLE: begin
          st_d = bus.code == 8'hF0 ? BRK : bus.code == 8'hE0 ? EXT : bus.code == 8'hE1 ? SKIP : IDLE;
          skip_d = 3'd7;
          ev.clr = bus.code inside {8'hAA, 8'hFC, 8'h00, 8'hFF};
          ev.v = st_d == IDLE;
        end
        BRK: begin
          ev.v = 1'b1;
          ev.brk = 1'b1;
          st_d = IDLE;
        end
        EXT: begin
          st_d = bus.code == 8'hF0 ? EXT_BRK : bus.code == 8'hE0 ? EXT : IDLE;
          ev.v = st_d == IDLE;
          ev.addr[8] = 1'b1;
        end
        EXT_BRK: begin
          ev.v = 1'b1;
          ev.brk = 1'b1;
          ev.addr[8] = 1'b1;
          st_d = IDLE;
        end
        SKIP: begin
          skip_d = skip_q - 3'd1;
          st_d = skip_q == 3'd1 ? IDLE : SKIP;
        end
        default: st_d = IDLE;
      endcase
    end else if (st_q != IDLE) begin
      to_d = to_q + 1'b1;
      st_d = to_q == TW'(TIMEOUT - 1) ? IDLE : st_q;
    end
    if (bus.clear_all) begin
      st_d = IDLE;
      ev = '0;
    end
  end
  // Apply stage: down-bit filter, saturating press counters and aux lines; clear_all flushes the pipe
  always_comb begin
    s1_d = bus.clear_all ? '0 : ev;
    s2_d = bus.clear_all ? '0 : s1_q;
    apply = s2_q.v && !s2_q.clr && s2_q.brk == down_q[s2_q.addr];
    clear = bus.clear_all || (s2_q.v && s2_q.clr);
    down_d = down_q;
    ctr_d = ctr_q;
    aux_d = aux_q;
    if (apply) down_d[s2_q.addr] = ~down_q[s2_q.addr];
    for (int i = 0; i < NK; i++) begin
      if (apply && ((kind inside {2'd1, 2'd2} && a == {RW'(i / COLS), CW'(i % COLS)}) ||
                    (kind == 2'd2 && b == {RW'(i / COLS), CW'(i % COLS)})))
        ctr_d[i] = s2_q.brk ? (ctr_q[i] == 2'd0 ? 2'd0 : ctr_q[i] - 2'd1)
                            : (ctr_q[i] == 2'd3 ? 2'd3 : ctr_q[i] + 2'd1);
    end
    for (int j = 0; j < NAUX; j++) begin
      if (apply && kind == 2'd3 && a == KW'(j)) aux_d[j] = s2_q.brk;
    end
    if (clear) begin
      ctr_d = '0;
      down_d = '0;
      aux_d = '1;
    end
  end
  // Column sense: a column is pulled low by any pressed key on a selected row
  always_comb begin
    bus.col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!bus.row[r] && ctr_q[r*COLS+c] != 2'd0) bus.col[c] = 1'b0;
  end
  // Keymap RAM: registered read, old data on a same-cycle write; never reset
  always_ff @(posedge clk) begin
    if (bus.map_we) map_mem[bus.map_addr] <= bus.map_data;
    ent_q <= map_mem[s1_q.addr];
  end
  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q <= IDLE;
      to_q <= '0;
      skip_q <= '0;
      s1_q <= '0;
      s2_q <= '0;
      ctr_q <= '0;
      down_q <= '0;
      aux_q <= '1;
    end else begin
      st_q <= st_d;
      to_q <= to_d;
      skip_q <= skip_d;
      s1_q <= s1_d;
      s2_q <= s2_d;
      ctr_q <= ctr_d;
      down_q <= down_d;
      aux_q <= aux_d;
    end
  end
endmodule

// File: tb/tb_key_matrix_map.sv
// tb_key_matrix_map: table vectors, directed corner sequences and random traffic against a keyboard model
module tb_key_matrix_map;
  localparam int ROWS = 8;
  localparam int COLS = 5;
  localparam int NAUX = 4;
  localparam int TIMEOUT = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  key_matrix_map_if #(.ROWS(ROWS), .COLS(COLS), .NAUX(NAUX)) bus ();
  key_matrix_map #(.ROWS(ROWS), .COLS(COLS), .NAUX(NAUX), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  typedef struct {
    logic [7:0] code;
    logic [7:0] row;
    logic [4:0] col;
    logic [3:0] aux;
  } vec_t;
  int errors = 0;
  int checks = 0;
  int m_kind [512];
  int m_a [512];
  int m_b [512];
  bit m_down [512];
  int m_cnt [ROWS][COLS];
  bit [NAUX-1:0] m_aux;
  bit m_brk, m_ext;
  int m_skip;

  task automatic check(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < 512; i++) m_down[i] = 1'b0;
    for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) m_cnt[r][c] = 0;
    m_aux = '1;
    m_brk = 1'b0;
    m_ext = 1'b0;
    m_skip = 0;
  endtask

  task automatic m_bump(int k, bit brk);
    int r, c;
    r = k >> 3;
    c = k & 7;
    if (r < ROWS && c < COLS)
      m_cnt[r][c] = brk ? (m_cnt[r][c] > 0 ? m_cnt[r][c] - 1 : 0) : (m_cnt[r][c] < 3 ? m_cnt[r][c] + 1 : 3);
  endtask

  task automatic m_event(int addr, bit brk);
    if (m_down[addr] != brk) return;
    m_down[addr] = !brk;
    if (m_kind[addr] == 1 || m_kind[addr] == 2) m_bump(m_a[addr], brk);
    if (m_kind[addr] == 2 && m_b[addr] != m_a[addr]) m_bump(m_b[addr], brk);
    if (m_kind[addr] == 3 && m_a[addr] < NAUX) m_aux[m_a[addr]] = brk;
  endtask

  task automatic m_byte(logic [7:0] b);
    if (m_skip > 0) m_skip--;
    else if (m_brk) begin
      m_event((m_ext ? 256 : 0) + int'(b), 1'b1);
      m_brk = 1'b0;
      m_ext = 1'b0;
    end
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) m_ext = 1'b1;
    else if (m_ext) begin
      m_event(256 + int'(b), 1'b0);
      m_ext = 1'b0;
    end
    else if (b == 8'hE1) m_skip = 7;
    else if (b == 8'hAA || b == 8'hFC || b == 8'h00 || b == 8'hFF) m_clear();
    else m_event(int'(b), 1'b0);
  endtask

  function automatic logic [COLS-1:0] m_col(logic [ROWS-1:0] rw);
    m_col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!rw[r] && m_cnt[r][c] > 0) m_col[c] = 1'b0;
  endfunction

  task automatic wmap(int addr, int kind, int a, int b);
    @(negedge clk);
    bus.map_we = 1'b1;
    bus.map_addr = 9'(addr);
    bus.map_data = {2'(kind), 6'(a), 6'(b)};
    @(posedge clk);
    #1 bus.map_we = 1'b0;
    m_kind[addr] = kind;
    m_a[addr] = a;
    m_b[addr] = b;
  endtask

  task automatic send(logic [7:0] b);
    @(negedge clk);
    bus.strb = 1'b1;
    bus.code = b;
    @(negedge clk);
    bus.strb = 1'b0;
    m_byte(b);
  endtask

  task automatic burst(logic [63:0] bytes, int n);
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      bus.strb = 1'b1;
      bus.code = bytes[8*(n-1-i) +: 8];
      m_byte(bytes[8*(n-1-i) +: 8]);
      @(negedge clk);
    end
    bus.strb = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(negedge clk);
    if (n >= TIMEOUT) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
      m_skip = 0;
    end
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic expect_col(string name, logic [7:0] rw, logic [4:0] exp);
    bus.row = rw;
    #1 check(name, bus.col, exp);
  endtask

  task automatic check_model(string name);
    for (int r = 0; r <= ROWS; r++) begin
      bus.row = r == ROWS ? '0 : ~(8'(1) << r);
      #1 check($sformatf("%s col row%0d", name, r), bus.col, m_col(bus.row));
    end
    check({name, " aux"}, bus.aux, m_aux);
    bus.row = '1;
  endtask

  task automatic pulse_clear_all();
    @(negedge clk);
    bus.clear_all = 1'b1;
    @(negedge clk);
    bus.clear_all = 1'b0;
    m_clear();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t tbl [18];
    logic [7:0] pool [12];
    tbl[0]  = '{8'h1A, 8'hFE, 5'b11101, 4'hF};
    tbl[1]  = '{8'hF0, 8'hFE, 5'b11101, 4'hF};
    tbl[2]  = '{8'h1A, 8'hFE, 5'b11111, 4'hF};
    tbl[3]  = '{8'h12, 8'hFE, 5'b11110, 4'hF};
    tbl[4]  = '{8'h54, 8'h7F, 5'b11101, 4'hF};
    tbl[5]  = '{8'h54, 8'hDF, 5'b11110, 4'hF};
    tbl[6]  = '{8'hF0, 8'h7F, 5'b11101, 4'hF};
    tbl[7]  = '{8'h54, 8'h7F, 5'b11111, 4'hF};
    tbl[8]  = '{8'hE0, 8'hFF, 5'b11111, 4'hF};
    tbl[9]  = '{8'h7D, 8'hFF, 5'b11111, 4'hE};
    tbl[10] = '{8'hE0, 8'hFF, 5'b11111, 4'hE};
    tbl[11] = '{8'hF0, 8'hFF, 5'b11111, 4'hE};
    tbl[12] = '{8'h7D, 8'hFF, 5'b11111, 4'hF};
    tbl[13] = '{8'h59, 8'hFE, 5'b11110, 4'hF};
    tbl[14] = '{8'hF0, 8'hFE, 5'b11110, 4'hF};
    tbl[15] = '{8'h12, 8'hFE, 5'b11110, 4'hF};
    tbl[16] = '{8'hF0, 8'hFE, 5'b11110, 4'hF};
    tbl[17] = '{8'h59, 8'hFE, 5'b11111, 4'hF};
    pool = '{8'h1A, 8'h12, 8'h54, 8'h59, 8'h7D, 8'h14, 8'h77, 8'h1C, 8'hF0, 8'hF0, 8'hE0, 8'h1B};
    bus.strb = 1'b0;
    bus.code = '0;
    bus.clear_all = 1'b0;
    bus.map_we = 1'b0;
    bus.map_addr = '0;
    bus.map_data = '0;
    bus.row = '1;
    for (int i = 0; i < 512; i++) wmap(i, 0, 0, 0);
    wmap(9'h01A, 1, 8'o01, 0);
    wmap(9'h012, 1, 8'o00, 0);
    wmap(9'h054, 2, 8'o71, 8'o50);
    wmap(9'h059, 1, 8'o00, 0);
    wmap(9'h17D, 3, 0, 0);
    wmap(9'h014, 1, 8'o10, 0);
    wmap(9'h077, 1, 8'o20, 0);
    wmap(9'h11A, 1, 8'o33, 0);
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    expect_col("reset col all rows", 8'h00, 5'b11111);
    check("reset aux", bus.aux, 4'hF);

    for (int i = 0; i < 18; i++) begin
      send(tbl[i].code);
      settle();
      expect_col($sformatf("vec%0d col", i), tbl[i].row, tbl[i].col);
      check($sformatf("vec%0d aux", i), bus.aux, tbl[i].aux);
    end

    repeat (5) send(8'h12);
    settle();
    expect_col("typematic held", 8'hFE, 5'b11110);
    send(8'hF0); send(8'h12);
    settle();
    expect_col("typematic released", 8'hFE, 5'b11111);

    send(8'h1A);
    burst({8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77}, 8);
    settle();
    expect_col("pause row1", 8'hFD, 5'b11111);
    expect_col("pause row2", 8'hFB, 5'b11111);
    expect_col("pause keeps 1A", 8'hFE, 5'b11101);
    send(8'h14);
    settle();
    expect_col("after pause 14", 8'hFD, 5'b11110);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h1A);
    settle();
    check_model("after pause");

    send(8'hE0);
    idle(TIMEOUT + 1);
    send(8'h1A);
    settle();
    expect_col("timeout plain 1A", 8'hFE, 5'b11101);
    expect_col("timeout not ext", 8'hF7, 5'b11111);
    send(8'hF0); send(8'h1A);
    send(8'hE0);
    idle(3);
    send(8'h1A);
    settle();
    expect_col("short wait ext", 8'hF7, 5'b10111);
    expect_col("short wait not plain", 8'hFE, 5'b11111);
    send(8'hE0); send(8'hF0); send(8'h1A);
    send(8'hF0);
    idle(TIMEOUT + 1);
    send(8'h1A);
    settle();
    expect_col("brk timeout is make", 8'hFE, 5'b11101);
    send(8'hF0); send(8'h1A);
    settle();
    check_model("after timeouts");

    send(8'h12); send(8'h1A); send(8'h54); send(8'hE0); send(8'h7D);
    settle();
    check_model("held before AA");
    send(8'hAA);
    settle();
    expect_col("AA col", 8'h00, 5'b11111);
    check("AA aux", bus.aux, 4'hF);
    send(8'hF0); send(8'h1A);
    settle();
    expect_col("no underflow", 8'h00, 5'b11111);
    send(8'h1A);
    settle();
    expect_col("press after clear", 8'hFE, 5'b11101);
    send(8'hE0); send(8'h7D);
    settle();
    pulse_clear_all();
    settle();
    expect_col("clear_all col", 8'h00, 5'b11111);
    check("clear_all aux", bus.aux, 4'hF);
    @(negedge clk);
    bus.strb = 1'b1;
    bus.code = 8'h1A;
    bus.clear_all = 1'b1;
    @(negedge clk);
    bus.strb = 1'b0;
    bus.clear_all = 1'b0;
    m_clear();
    settle();
    expect_col("clear_all beats event", 8'hFE, 5'b11111);

    send(8'hF0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    m_clear();
    send(8'h1A);
    settle();
    expect_col("reset drops F0", 8'hFE, 5'b11101);

    burst({8'h12, 8'hF0, 8'h1A, 8'h1A, 8'hF0, 8'h12}, 6);
    settle();
    expect_col("b2b mixed", 8'hFE, 5'b11101);
    burst({8'hF0, 8'h1A, 8'h1A, 8'hF0, 8'h1A}, 5);
    settle();
    expect_col("b2b brk make brk", 8'hFE, 5'b11111);
    check_model("b2b");

    @(negedge clk);
    bus.strb = 1'b1;
    bus.code = 8'h1A;
    @(negedge clk);
    bus.strb = 1'b0;
    m_byte(8'h1A);
    bus.map_we = 1'b1;
    bus.map_addr = 9'h01A;
    bus.map_data = {2'd1, 6'o22, 6'o00};
    @(negedge clk);
    bus.map_we = 1'b0;
    m_kind[9'h01A] = 1;
    m_a[9'h01A] = 8'o22;
    m_b[9'h01A] = 0;
    settle();
    expect_col("map wr old entry", 8'hFE, 5'b11101);
    expect_col("map wr new unused", 8'hFB, 5'b11111);
    send(8'hF0); send(8'h1A);
    settle();
    expect_col("map wr old stays", 8'hFE, 5'b11101);
    expect_col("map wr new sat", 8'hFB, 5'b11111);
    send(8'hAA);
    wmap(9'h01A, 1, 8'o01, 0);

    for (int i = 0; i < 12; i++) begin
      wmap(int'(pool[i]), int'($urandom_range(0, 3)), int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      wmap(256 + int'(pool[i]), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 63)));
    end
    for (int n = 0; n < 400; n++) begin
      send($urandom_range(0, 60) == 0 ? 8'hAA : pool[$urandom_range(0, 11)]);
      if ($urandom_range(0, 3) == 0) idle(1);
      if (n % 20 == 19) begin
        settle();
        check_model($sformatf("rand%0d", n));
      end
    end
    settle();
    check_model("rand end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
